// File: rtl/branch_amend_stage_if.sv
// Bundle, control and redirect signals between EXE_up, the branch-amend stage,
// PREMEM/REEXE and the front end. Master drives the bundle in, slave is the stage.
interface branch_amend_stage_if #(
    parameter int LANES    = 2,
    parameter int DATA_W   = 32,
    parameter int GPR_W    = 5,
    parameter int CKPT_W   = 16,
    parameter int REPAIR_W = 4
);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic                       in_valid;
    logic [LANES-1:0]           in_lane_mask;
    logic [LANES*DATA_W-1:0]    in_vaddr;
    logic [LANES*DATA_W-1:0]    in_alu_res;
    logic [LANES*GPR_W-1:0]     in_write_num;
    logic [LANES*DATA_W-1:0]    in_corr_dest;
    logic [LANES-1:0]           in_corr_take;
    logic [LANES*REPAIR_W-1:0]  in_repair;
    logic [LANES*CKPT_W-1:0]    in_ckpt;
    logic                       mem_risk;
    logic                       exc_flush;
    logic                       down_allowin;

    logic                       allowin;
    logic                       out_valid;
    logic [LANES-1:0]           out_lane_mask;
    logic [LANES*DATA_W-1:0]    out_vaddr;
    logic [LANES*DATA_W-1:0]    out_alu_res;
    logic [LANES*GPR_W-1:0]     out_write_num;
    logic [LANES-1:0]           fwd_mask;
    logic                       flush;
    logic [LANE_W-1:0]          flush_lane;
    logic [DATA_W-1:0]          flush_vaddr;
    logic [DATA_W-1:0]          flush_dest;
    logic                       flush_take;
    logic [REPAIR_W-1:0]        flush_repair;
    logic [CKPT_W-1:0]          flush_ckpt;

    modport master (
        output in_valid, in_lane_mask, in_vaddr, in_alu_res, in_write_num,
               in_corr_dest, in_corr_take, in_repair, in_ckpt,
               mem_risk, exc_flush, down_allowin,
        input  allowin, out_valid, out_lane_mask, out_vaddr, out_alu_res,
               out_write_num, fwd_mask, flush, flush_lane, flush_vaddr,
               flush_dest, flush_take, flush_repair, flush_ckpt
    );

    modport slave (
        input  in_valid, in_lane_mask, in_vaddr, in_alu_res, in_write_num,
               in_corr_dest, in_corr_take, in_repair, in_ckpt,
               mem_risk, exc_flush, down_allowin,
        output allowin, out_valid, out_lane_mask, out_vaddr, out_alu_res,
               out_write_num, fwd_mask, flush, flush_lane, flush_vaddr,
               flush_dest, flush_take, flush_repair, flush_ckpt
    );
endinterface

// File: rtl/branch_amend_stage.sv
// Multi-lane branch-amend register stage: holds one resolved bundle, redirects the
// front end once from the oldest repairing lane and kills the lanes behind it.
module branch_amend_stage #(
    parameter int LANES    = 2,
    parameter int DATA_W   = 32,
    parameter int GPR_W    = 5,
    parameter int CKPT_W   = 16,
    parameter int REPAIR_W = 4,
    parameter int KEEP_DS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_amend_stage_if.slave  bus
);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic                       has_data_q, has_data_d;
    logic                       flushed_q,  flushed_d;
    logic [LANES-1:0]           mask_q,     mask_d;
    logic [LANES*DATA_W-1:0]    vaddr_q,    vaddr_d;
    logic [LANES*DATA_W-1:0]    alu_q,      alu_d;
    logic [LANES*GPR_W-1:0]     wnum_q,     wnum_d;
    logic [LANES*DATA_W-1:0]    dest_q,     dest_d;
    logic [LANES-1:0]           take_q,     take_d;
    logic [LANES*REPAIR_W-1:0]  repair_q,   repair_d;
    logic [LANES*CKPT_W-1:0]    ckpt_q,     ckpt_d;

    logic [LANES-1:0]           rep_vec;
    logic [LANES-1:0]           keep_vec;
    logic [LANES-1:0]           live_mask;
    logic                       any_rep;
    int                         sel_idx;
    logic                       ready;
    logic                       allowin;
    logic                       flush;
    logic                       accept;
    logic [DATA_W-1:0]          fl_vaddr;
    logic [DATA_W-1:0]          fl_dest;
    logic                       fl_take;
    logic [REPAIR_W-1:0]        fl_repair;
    logic [CKPT_W-1:0]          fl_ckpt;

    always_comb begin
        rep_vec = '0;
        for (int i = 0; i < LANES; i++) begin
            rep_vec[i] = mask_q[i] & repair_q[i*REPAIR_W];
        end
    end

    assign any_rep = |rep_vec;

    // Scanning downward leaves the oldest (lowest) repairing lane selected.
    always_comb begin
        sel_idx = 0;
        for (int i = LANES-1; i >= 0; i--) begin
            if (rep_vec[i]) sel_idx = i;
        end
    end

    always_comb begin
        keep_vec = '1;
        if (any_rep) begin
            for (int i = 0; i < LANES; i++) begin
                if (i > sel_idx + KEEP_DS) keep_vec[i] = 1'b0;
            end
        end
    end

    assign live_mask = mask_q & keep_vec;

    always_comb begin
        fl_vaddr  = '0;
        fl_dest   = '0;
        fl_take   = 1'b0;
        fl_repair = '0;
        fl_ckpt   = '0;
        for (int i = 0; i < LANES; i++) begin
            if (any_rep && (i == sel_idx)) begin
                fl_vaddr  = vaddr_q[i*DATA_W +: DATA_W];
                fl_dest   = dest_q[i*DATA_W +: DATA_W];
                fl_take   = take_q[i];
                fl_repair = repair_q[i*REPAIR_W +: REPAIR_W];
                fl_ckpt   = ckpt_q[i*CKPT_W +: CKPT_W];
            end
        end
    end

    // A repairing bundle must not redirect or leave while MEM may still raise an exception.
    assign ready   = !(bus.mem_risk & any_rep);
    assign allowin = !has_data_q | (ready & bus.down_allowin);
    assign flush   = has_data_q & any_rep & !bus.mem_risk & !flushed_q & !bus.exc_flush;
    assign accept  = allowin & bus.in_valid & !flush;

    always_comb begin
        has_data_d = has_data_q;
        mask_d     = mask_q;
        vaddr_d    = vaddr_q;
        alu_d      = alu_q;
        wnum_d     = wnum_q;
        dest_d     = dest_q;
        take_d     = take_q;
        repair_d   = repair_q;
        ckpt_d     = ckpt_q;
        if (bus.exc_flush) begin
            has_data_d = 1'b0;
            mask_d     = '0;
            vaddr_d    = '0;
            alu_d      = '0;
            wnum_d     = '0;
            dest_d     = '0;
            take_d     = '0;
            repair_d   = '0;
            ckpt_d     = '0;
        end else if (allowin) begin
            has_data_d = accept;
            if (accept) begin
                mask_d   = bus.in_lane_mask;
                vaddr_d  = bus.in_vaddr;
                alu_d    = bus.in_alu_res;
                wnum_d   = bus.in_write_num;
                dest_d   = bus.in_corr_dest;
                take_d   = bus.in_corr_take;
                repair_d = bus.in_repair;
                ckpt_d   = bus.in_ckpt;
            end
        end
    end

    // One redirect per resident bundle: cleared only when the bundle leaves or is replaced.
    always_comb begin
        flushed_d = flushed_q;
        if (bus.exc_flush || allowin) flushed_d = 1'b0;
        else if (flush)               flushed_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            has_data_q <= 1'b0;
            flushed_q  <= 1'b0;
            mask_q     <= '0;
            vaddr_q    <= '0;
            alu_q      <= '0;
            wnum_q     <= '0;
            dest_q     <= '0;
            take_q     <= '0;
            repair_q   <= '0;
            ckpt_q     <= '0;
        end else begin
            has_data_q <= has_data_d;
            flushed_q  <= flushed_d;
            mask_q     <= mask_d;
            vaddr_q    <= vaddr_d;
            alu_q      <= alu_d;
            wnum_q     <= wnum_d;
            dest_q     <= dest_d;
            take_q     <= take_d;
            repair_q   <= repair_d;
            ckpt_q     <= ckpt_d;
        end
    end

    assign bus.allowin       = allowin;
    assign bus.out_valid     = has_data_q & ready & bus.down_allowin & !bus.exc_flush;
    assign bus.out_lane_mask = live_mask;
    assign bus.out_vaddr     = vaddr_q;
    assign bus.out_alu_res   = alu_q;
    assign bus.out_write_num = wnum_q;
    assign bus.fwd_mask      = live_mask & {LANES{has_data_q & ready}};
    assign bus.flush         = flush;
    assign bus.flush_lane    = any_rep ? LANE_W'(sel_idx) : '0;
    assign bus.flush_vaddr   = fl_vaddr;
    assign bus.flush_dest    = fl_dest;
    assign bus.flush_take    = fl_take;
    assign bus.flush_repair  = fl_repair;
    assign bus.flush_ckpt    = fl_ckpt;
endmodule

// File: doc/branch_amend_stage.md
Name: branch_amend_stage

Overview:
- Parametrised multi-lane successor of the PREMEM branch-amend register stage. Sits between EXE_up and PREMEM/REEXE.
- Latches a bundle of up to LANES resolved instructions per cycle. Selects the oldest mispredicted lane and raises a one-shot redirect toward the front end.
- Kills lanes younger than the branch and its delay slot.
- Holds the bundle while MEM reports a risk, so a redirect is never issued under a pending exception.

Parameters:
LANES, 2, lanes per bundle; lane 0 is oldest
DATA_W, 32, VAddr/aluRes/dest width
GPR_W, 5, writeback register number width
CKPT_W, 16, checkpoint width per lane
REPAIR_W, 4, repair-action width per lane; bit 0 = NEED_REPAIR
KEEP_DS, 1, 1 = lane after the mispredicting lane (delay slot) survives

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  EXE_up bundle valid
in_lane_mask  in  LANES  per-lane occupancy
in_vaddr  in  LANES*DATA_W  per-lane PC
in_alu_res  in  LANES*DATA_W  per-lane result
in_write_num  in  LANES*GPR_W  per-lane dest GPR, 0 = none
in_corr_dest  in  LANES*DATA_W  resolved target
in_corr_take  in  LANES  resolved direction
in_repair  in  LANES*REPAIR_W  repair action
in_ckpt  in  LANES*CKPT_W  checkpoint
mem_risk  in  1  MEM holds an unresolved exception risk
exc_flush  in  1  CP0 exception flush covering this stage
down_allowin  in  1  PREMEM/REEXE can accept
allowin  out  1  stage can accept
out_valid  out  1  bundle handed downstream this cycle
out_lane_mask  out  LANES  surviving lanes
out_vaddr / out_alu_res / out_write_num  out  as inputs  registered copies
fwd_mask  out  LANES  lanes whose results may be forwarded
flush  out  1  redirect pulse
flush_lane  out  $clog2(LANES)  index of the redirecting lane
flush_vaddr / flush_dest  out  DATA_W  PC and correct target of that lane
flush_take  out  1  correct direction
flush_repair  out  REPAIR_W  repair action of that lane
flush_ckpt  out  CKPT_W  checkpoint of that lane

Behaviour:
- Reset (async, rst=1):
  - has_data=0, flushed=0, all registers 0.
  - Every output is 0, except allowin, which is 1.
- Repair detection:
  - rep_vec[i] = stored_mask[i] & repair[i][0].
  - any_rep = |rep_vec.
  - sel = lowest set index of rep_vec.
- Control equations:
  - ready = !(mem_risk & any_rep).
  - out_valid = has_data & ready & down_allowin & !exc_flush.
  - allowin = !has_data | (ready & down_allowin).
  - flush = has_data & any_rep & !mem_risk & !flushed & !exc_flush.
  - accept = allowin & in_valid & !flush. A bundle arriving in the same cycle as a flush pulse is younger and is dropped.
- Next-state rules, in priority order:
  - exc_flush: has_data=0 and all payload cleared.
  - Otherwise, when allowin=1: has_data=accept, and payload loads on accept.
  - Otherwise: hold.
- flushed:
  - Set when flush=1.
  - Cleared whenever allowin=1, i.e. when a new bundle loads or the stage empties.
  - Guarantees exactly one flush pulse per bundle, even if down_allowin stalls for many cycles.
- Lane mask and forwarding:
  - out_lane_mask = stored_mask with lanes > sel+KEEP_DS cleared when any_rep; otherwise stored_mask.
  - fwd_mask = out_lane_mask & {LANES{has_data & ready}}.
- Flush payload:
  - flush_* fields are muxed from lane sel.
  - They are valid only while flush=1 and are 0 when no lane repairs.
- mem_risk stall:
  - mem_risk with any_rep stalls the bundle: ready=0, no flush, allowin=0.
  - When mem_risk drops, flush fires in that cycle.
- Lanes without repair are not blocked by mem_risk.
- Reset asserted mid-operation discards the bundle and any pending flush immediately.

Test Plan:
- LANES=2, in_valid, mask=11, no repair, down_allowin=1 -> next cycle out_valid=1, mask=11, flush=0; back-to-back bundles stream one per cycle.
- Lane 0 repair, vaddr=0xBFC00100, dest=0xBFC00200, take=1, KEEP_DS=1 -> flush=1 for exactly 1 cycle with flush_lane=0 and those values; out_lane_mask=11.
- LANES=4, repair on lanes 1 and 2 -> flush_lane=1; out_lane_mask=0111 from stored 1111.
- Lane 0 repair with mem_risk=1 for 3 cycles -> flush=0, allowin=0, out_valid=0 for those 3 cycles; then flush=1 in the cycle mem_risk falls.
- down_allowin=0 for 5 cycles with a repair bundle -> flush pulses once only; an in_valid bundle presented in the flush cycle is not loaded.
- exc_flush while holding a repair bundle -> flush=0 and out_valid=0 in that cycle; has_data=0 next cycle. Async rst mid-stall -> all outputs 0 and allowin=1 immediately.
